// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
//  - state_t       : controller FSM states
//  - OP_* / FN_*   : opcode and R-type funct encodings
//  - alu_op_t      : ALU function codes driven on alu_operation
//  - instr_class_t : decoded instruction class used by the FSM
package mips_ctrl_pkg;

    localparam int unsigned OPC_W     = 6;
    localparam int unsigned ALU_CODE_W = 4;
    localparam int unsigned CLASS_W   = 4;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OP_J     = 6'h02;
    localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OPC_W-1:0] FN_ADD     = 6'h20;
    localparam logic [OPC_W-1:0] FN_SUB     = 6'h22;
    localparam logic [OPC_W-1:0] FN_AND     = 6'h24;
    localparam logic [OPC_W-1:0] FN_OR      = 6'h25;
    localparam logic [OPC_W-1:0] FN_SLT     = 6'h2A;
    localparam logic [OPC_W-1:0] FN_JR      = 6'h08;
    localparam logic [OPC_W-1:0] FN_SYSCALL = 6'h0C;

    typedef enum logic [ALU_CODE_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4
    } alu_op_t;

    typedef enum logic [CLASS_W-1:0] {
        CLS_RTYPE   = 4'd0,
        CLS_LW      = 4'd1,
        CLS_SW      = 4'd2,
        CLS_ADDI    = 4'd3,
        CLS_BEQ     = 4'd4,
        CLS_BNE     = 4'd5,
        CLS_J       = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JR      = 4'd8,
        CLS_SYSCALL = 4'd9
    } instr_class_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure combinational instruction decoder.
// Ports:
//  i_opcode  in  6  latched inst[31:26]
//  i_funct   in  6  latched inst[5:0]
//  o_class   out 4  instruction class (instr_class_t encoding)
//  o_alu_op  out 4  ALU function for EXEC (alu_op_t encoding)
//  o_illegal out 1  opcode or R-type funct not in the supported map
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_class,
    output logic [3:0] o_alu_op,
    output logic       o_illegal
);

    // Jumps and unrecognised encodings leave the ALU on ADD.
    always_comb begin
        o_class   = CLS_RTYPE;
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD:     o_alu_op = ALU_ADD;
                    FN_SUB:     o_alu_op = ALU_SUB;
                    FN_AND:     o_alu_op = ALU_AND;
                    FN_OR:      o_alu_op = ALU_OR;
                    FN_SLT:     o_alu_op = ALU_SLT;
                    FN_JR:      o_class  = CLS_JR;
                    FN_SYSCALL: o_class  = CLS_SYSCALL;
                    default:    o_illegal = 1'b1;
                endcase
            end
            OP_J:    o_class = CLS_J;
            OP_JAL:  o_class = CLS_JAL;
            OP_BEQ: begin
                o_class  = CLS_BEQ;
                o_alu_op = ALU_SUB;
            end
            OP_BNE: begin
                o_class  = CLS_BNE;
                o_alu_op = ALU_SUB;
            end
            OP_ADDI: o_class = CLS_ADDI;
            OP_LW:   o_class = CLS_LW;
            OP_SW:   o_class = CLS_SW;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a
// req/ready memory handshake and a wait-state watchdog.
// Ports:
//  clk, rst_b (sync, active-high)   clock / reset
//  opcode, funct                    instruction fields, captured on ir_write
//  alu_zero                         ALU zero flag, used in EXEC for branches
//  mem_ready                        memory completes current request
//  mem_req, mem_write_en            memory request / store strobe
//  ir_write, pc_write               IR latch / PC update enables
//  alu_src, reg_dest, mem_or_reg, reg_or_mem   datapath mux selects
//  alu_operation                    ALU function code
//  reg_write_enable                 register file write
//  branch, jump, jump_register, link           next-PC / link selects
//  halted, error                    sticky stop / fault flags
// Outputs are combinational from the registered state so nothing lags it;
// everything is forced low in the reset cycle.
module mips_mc_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_W     = 4,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_write_en,
    output logic                ir_write,
    output logic                pc_write,
    output logic                alu_src,
    output logic                reg_dest,
    output logic                mem_or_reg,
    output logic                reg_or_mem,
    output logic [ALU_OP_W-1:0] alu_operation,
    output logic                reg_write_enable,
    output logic                branch,
    output logic                jump,
    output logic                jump_register,
    output logic                link,
    output logic                halted,
    output logic                error
);

    localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nx;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic             r_error;
    logic             w_error_set;
    logic             w_capture;
    logic             w_timeout;
    logic [3:0]       w_class;
    logic [3:0]       w_alu_op;
    logic             w_illegal;

    mips_ctrl_decode u_decode (
        .i_opcode  (r_opcode),
        .i_funct   (r_funct),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

    assign w_timeout = (r_wait_cnt == CNT_W'(MEM_WAIT_MAX));

    // State, watchdog counter, latched instruction fields and sticky error.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state    <= FETCH;
            r_wait_cnt <= '0;
            r_opcode   <= '0;
            r_funct    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_cnt_nx;
            if (w_capture) begin
                r_opcode <= opcode;
                r_funct  <= funct;
            end
            if (w_error_set) begin
                r_error <= 1'b1;
            end
        end
    end

    // Next-state and control outputs.
    always_comb begin
        w_next           = r_state;
        w_error_set      = 1'b0;
        w_capture        = 1'b0;
        mem_req          = 1'b0;
        mem_write_en     = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        alu_src          = 1'b0;
        reg_dest         = 1'b0;
        mem_or_reg       = 1'b0;
        reg_or_mem       = 1'b0;
        alu_operation    = '0;
        reg_write_enable = 1'b0;
        branch           = 1'b0;
        jump             = 1'b0;
        jump_register    = 1'b0;
        link             = 1'b0;
        halted           = 1'b0;
        error            = r_error;

        case (r_state)
            FETCH: begin
                if (w_timeout) begin
                    w_next      = HALT;
                    w_error_set = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        w_capture = 1'b1;
                        w_next    = DECODE;
                    end
                end
            end
            DECODE: begin
                if (w_illegal) begin
                    w_next      = HALT;
                    w_error_set = 1'b1;
                end else if (w_class == CLS_SYSCALL) begin
                    w_next = HALT;
                end else begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                alu_operation = ALU_OP_W'(w_alu_op);
                case (w_class)
                    CLS_RTYPE: w_next = WB;
                    CLS_LW, CLS_SW: begin
                        alu_src = 1'b1;
                        w_next  = MEM;
                    end
                    CLS_ADDI: begin
                        alu_src = 1'b1;
                        w_next  = WB;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        branch   = 1'b1;
                        // bne inverts the sense of the zero flag.
                        pc_write = alu_zero ^ (w_class == CLS_BNE);
                        w_next   = FETCH;
                    end
                    CLS_J: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        w_next   = FETCH;
                    end
                    CLS_JAL: begin
                        jump             = 1'b1;
                        link             = 1'b1;
                        reg_write_enable = 1'b1;
                        pc_write         = 1'b1;
                        w_next           = FETCH;
                    end
                    CLS_JR: begin
                        jump_register = 1'b1;
                        pc_write      = 1'b1;
                        w_next        = FETCH;
                    end
                    default: begin
                        w_next      = HALT;
                        w_error_set = 1'b1;
                    end
                endcase
            end
            MEM: begin
                if (w_timeout) begin
                    w_next      = HALT;
                    w_error_set = 1'b1;
                end else begin
                    mem_req      = 1'b1;
                    mem_write_en = (w_class == CLS_SW);
                    if (mem_ready) begin
                        w_next = (w_class == CLS_SW) ? FETCH : WB;
                    end
                end
            end
            WB: begin
                reg_write_enable = 1'b1;
                reg_dest         = (w_class == CLS_RTYPE);
                mem_or_reg       = (w_class == CLS_LW);
                w_next           = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = HALT;
            end
        endcase

        // Count unanswered request cycles; any state change or ready clears.
        if ((w_next == r_state) && mem_req && !mem_ready) begin
            w_wait_cnt_nx = r_wait_cnt + CNT_W'(1);
        end else begin
            w_wait_cnt_nx = '0;
        end

        if (rst_b) begin
            mem_req          = 1'b0;
            mem_write_en     = 1'b0;
            ir_write         = 1'b0;
            pc_write         = 1'b0;
            alu_src          = 1'b0;
            reg_dest         = 1'b0;
            mem_or_reg       = 1'b0;
            reg_or_mem       = 1'b0;
            alu_operation    = '0;
            reg_write_enable = 1'b0;
            branch           = 1'b0;
            jump             = 1'b0;
            jump_register    = 1'b0;
            link             = 1'b0;
            halted           = 1'b0;
            error            = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: every cycle the full control
// vector is compared against a per-instruction expected schedule built from
// the instruction's class, its memory wait pattern and the branch flag.
module tb_mips_mc_controller;

    localparam int B_REQ  = 18;
    localparam int B_WE   = 17;
    localparam int B_IRW  = 16;
    localparam int B_PCW  = 15;
    localparam int B_ASRC = 14;
    localparam int B_RDST = 13;
    localparam int B_MOR  = 12;
    localparam int B_ALU  = 7;
    localparam int B_RWE  = 6;
    localparam int B_BR   = 5;
    localparam int B_J    = 4;
    localparam int B_JR   = 3;
    localparam int B_LNK  = 2;
    localparam int B_HLT  = 1;
    localparam int B_ERR  = 0;

    // instruction classes used by the model
    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_ADDI = 3, C_BEQ = 4, C_BNE = 5;
    localparam int C_J = 6, C_JAL = 7, C_JR = 8, C_SYS = 9, C_ILL = 10;

    logic       clk;
    logic       rst_b;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_write_en, ir_write, pc_write;
    logic       alu_src, reg_dest, mem_or_reg, reg_or_mem;
    logic [3:0] alu_operation;
    logic       reg_write_enable, branch, jump, jump_register, link;
    logic       halted, error;
    logic [18:0] dut_v;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rdy;
        logic [18:0] v;
        string       tag;
    } step_t;

    mips_mc_controller #(.ALU_OP_W(4), .MEM_WAIT_MAX(15)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .opcode           (opcode),
        .funct            (funct),
        .alu_zero         (alu_zero),
        .mem_ready        (mem_ready),
        .mem_req          (mem_req),
        .mem_write_en     (mem_write_en),
        .ir_write         (ir_write),
        .pc_write         (pc_write),
        .alu_src          (alu_src),
        .reg_dest         (reg_dest),
        .mem_or_reg       (mem_or_reg),
        .reg_or_mem       (reg_or_mem),
        .alu_operation    (alu_operation),
        .reg_write_enable (reg_write_enable),
        .branch           (branch),
        .jump             (jump),
        .jump_register    (jump_register),
        .link             (link),
        .halted           (halted),
        .error            (error)
    );

    assign dut_v = {mem_req, mem_write_en, ir_write, pc_write, alu_src, reg_dest,
                    mem_or_reg, reg_or_mem, alu_operation, reg_write_enable,
                    branch, jump, jump_register, link, halted, error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return C_R;
                    6'h08: return C_JR;
                    6'h0C: return C_SYS;
                    default: return C_ILL;
                endcase
            end
            6'h02: return C_J;
            6'h03: return C_JAL;
            6'h04: return C_BEQ;
            6'h05: return C_BNE;
            6'h08: return C_ADDI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h04 || op == 6'h05) return 4'd1;
        if (op != 6'h00) return 4'd0;
        case (fn)
            6'h22: return 4'd1;
            6'h24: return 4'd2;
            6'h25: return 4'd3;
            6'h2A: return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    function automatic step_t mk(input logic r, input logic [18:0] v, input string t);
        step_t s;
        s.rdy = r;
        s.v   = v;
        s.tag = t;
        return s;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one instruction from FETCH to its last cycle, comparing every cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic zr);
        step_t       q[$];
        logic [18:0] e;
        int          cls;
        cls = classify(op, fn);
        opcode   = op;
        funct    = fn;
        alu_zero = zr;
        for (int i = 0; i < fw; i++) begin
            e = '0; e[B_REQ] = 1'b1;
            q.push_back(mk(1'b0, e, "fetch_wait"));
        end
        e = '0; e[B_REQ] = 1'b1; e[B_IRW] = 1'b1; e[B_PCW] = 1'b1;
        q.push_back(mk(1'b1, e, "fetch_ready"));
        q.push_back(mk(rbit(), '0, "decode"));
        if (cls == C_ILL || cls == C_SYS) begin
            for (int i = 0; i < 3; i++) begin
                e = '0; e[B_HLT] = 1'b1; e[B_ERR] = (cls == C_ILL);
                q.push_back(mk(rbit(), e, "halt"));
            end
        end else begin
            e = '0;
            e[B_ALU +: 4] = alu_code(op, fn);
            case (cls)
                C_LW, C_SW, C_ADDI: e[B_ASRC] = 1'b1;
                C_BEQ: begin e[B_BR] = 1'b1; e[B_PCW] = zr; end
                C_BNE: begin e[B_BR] = 1'b1; e[B_PCW] = ~zr; end
                C_J:   begin e[B_J] = 1'b1; e[B_PCW] = 1'b1; end
                C_JAL: begin e[B_J] = 1'b1; e[B_LNK] = 1'b1; e[B_RWE] = 1'b1; e[B_PCW] = 1'b1; end
                C_JR:  begin e[B_JR] = 1'b1; e[B_PCW] = 1'b1; end
                default: ;
            endcase
            q.push_back(mk(rbit(), e, "exec"));
            if (cls == C_LW || cls == C_SW) begin
                e = '0; e[B_REQ] = 1'b1; e[B_WE] = (cls == C_SW);
                for (int i = 0; i < mw; i++) q.push_back(mk(1'b0, e, "mem_wait"));
                q.push_back(mk(1'b1, e, "mem_ready"));
            end
            if (cls == C_R || cls == C_LW || cls == C_ADDI) begin
                e = '0; e[B_RWE] = 1'b1; e[B_RDST] = (cls == C_R); e[B_MOR] = (cls == C_LW);
                q.push_back(mk(rbit(), e, "wb"));
            end
        end
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            #2;
            n_checks++;
            if (dut_v !== q[i].v) begin
                n_errors++;
                $display("FAIL %s op=%h fn=%h step=%0d: got %b expected %b",
                         q[i].tag, op, fn, i, dut_v, q[i].v);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset(input int n);
        rst_b = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_ready = rbit();
            #2;
            n_checks++;
            if (dut_v !== 19'd0) begin
                n_errors++;
                $display("FAIL reset_cycle %0d: got %b expected all zero", i, dut_v);
            end
            @(posedge clk); #1;
        end
        rst_b = 1'b0;
    endtask

    task automatic test_basic();
        run_instr(6'h00, 6'h20, 0, 0, 1'b0);   // add, 4 cycles
        run_instr(6'h23, 6'h11, 3, 2, 1'b0);   // lw, 10 cycles with waits
        run_instr(6'h04, 6'h00, 0, 0, 1'b1);   // beq taken
        run_instr(6'h05, 6'h00, 0, 0, 1'b1);   // bne not taken
        run_instr(6'h04, 6'h00, 1, 0, 1'b0);
        run_instr(6'h05, 6'h00, 0, 0, 1'b0);
        run_instr(6'h03, 6'h00, 0, 0, 1'b0);   // jal
        run_instr(6'h02, 6'h3F, 0, 0, 1'b0);   // j
        run_instr(6'h00, 6'h08, 0, 0, 1'b0);   // jr
        run_instr(6'h2B, 6'h00, 0, 0, 1'b0);   // sw zero-wait
        run_instr(6'h08, 6'h00, 2, 0, 1'b1);   // addi
    endtask

    task automatic test_random(input int n);
        logic [5:0] ops [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
        logic [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08};
        int k;
        logic [5:0] fn;
        for (int i = 0; i < n; i++) begin
            k  = int'($urandom_range(0, 12));
            fn = (k < 6) ? fns[k] : 6'($urandom);
            run_instr(ops[k], fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rbit());
        end
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0);
        test_reset(1);
        run_instr(6'h00, 6'h21, 1, 0, 1'b0);   // unsupported funct
        test_reset(1);
    endtask

    task automatic test_timeout();
        logic [18:0] e;
        opcode = 6'h00; funct = 6'h20;
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'b0;
            e = '0;
            if (i < 15) e[B_REQ] = 1'b1;
            else if (i > 15) begin e[B_HLT] = 1'b1; e[B_ERR] = 1'b1; end
            #2;
            n_checks++;
            if (dut_v !== e) begin
                n_errors++;
                $display("FAIL timeout cycle %0d: got %b expected %b", i, dut_v, e);
            end
            @(posedge clk); #1;
        end
        test_reset(1);
    endtask

    task automatic test_syscall_and_mid_reset();
        logic [18:0] e;
        run_instr(6'h00, 6'h0C, 0, 0, 1'b0);
        test_reset(1);
        // sw up to a long MEM wait, then reset in the middle of it
        opcode = 6'h2B; funct = 6'h00;
        for (int i = 0; i < 11; i++) begin
            e = '0;
            mem_ready = 1'b0;
            if (i == 0) begin mem_ready = 1'b1; e[B_REQ] = 1'b1; e[B_IRW] = 1'b1; e[B_PCW] = 1'b1; end
            else if (i == 2) e[B_ASRC] = 1'b1;
            else if (i > 2) begin e[B_REQ] = 1'b1; e[B_WE] = 1'b1; end
            #2;
            n_checks++;
            if (dut_v !== e) begin
                n_errors++;
                $display("FAIL sw_mem_wait cycle %0d: got %b expected %b", i, dut_v, e);
            end
            @(posedge clk); #1;
        end
        test_reset(1);
        // wait counter must be cleared: 14 more waits must not time out
        run_instr(6'h00, 6'h25, 14, 0, 1'b0);
    endtask

    initial begin
        rst_b     = 1'b1;
        opcode    = '0;
        funct     = '0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset(2);
        test_basic();
        test_random(40);
        test_illegal();
        test_timeout();
        test_syscall_and_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
